// File: rtl/systolic_ctrl_2by2_pkg.sv
// Shared constants and state encoding for the 2x2 systolic array sequencer.
// Optional build macro used by the top: SYSA_PERF_CNT_EN.
package sysa_pkg;

    // Default element width of operands and results.
    localparam int SYSA_DW = 8;

    // Number of cycles that operands are streamed into the array.
    localparam int FEED_LEN = 4;

    // Element positions inside a packed matrix {x22, x21, x12, x11}.
    localparam int IDX_11 = 0;
    localparam int IDX_12 = 1;
    localparam int IDX_21 = 2;
    localparam int IDX_22 = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sysa_state_e;

endpackage

// File: rtl/systolic_ctrl_2by2_if.sv
// Host-side request/result bundle of the systolic array sequencer.
// The host (master) posts operands with start and consumes res with res_ready.
interface systolic_ctrl_2by2_if #(
    parameter int DW = 8
);
    logic              start;
    logic [4*DW-1:0]   mat_a;
    logic [4*DW-1:0]   mat_b;
    logic              busy;
    logic [4*DW-1:0]   res;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output start, mat_a, mat_b, res_ready,
        input  busy, res, res_valid
    );

    modport slave (
        input  start, mat_a, mat_b, res_ready,
        output busy, res, res_valid
    );
endinterface

// File: rtl/systolic_ctrl_2by2_feed_mux.sv
// Skewed operand feed decode for the 2x2 array. Purely combinational from the
// registered feed flag, feed index and latched operands, so no input-to-output
// path exists through the controller.
module sysa_feed_mux_2by2
    import sysa_pkg::*;
#(
    parameter int DW = SYSA_DW
) (
    input  logic              feed_en,
    input  logic [1:0]        k,
    input  logic [4*DW-1:0]   op_a,
    input  logic [4*DW-1:0]   op_b,
    output logic [DW-1:0]     a1,
    output logic [DW-1:0]     a2,
    output logic [DW-1:0]     b1,
    output logic [DW-1:0]     b2
);

    logic [DW-1:0] a11, a12, a21, a22;
    logic [DW-1:0] b11, b12, b21, b22;

    assign a11 = op_a[IDX_11*DW +: DW];
    assign a12 = op_a[IDX_12*DW +: DW];
    assign a21 = op_a[IDX_21*DW +: DW];
    assign a22 = op_a[IDX_22*DW +: DW];
    assign b11 = op_b[IDX_11*DW +: DW];
    assign b12 = op_b[IDX_12*DW +: DW];
    assign b21 = op_b[IDX_21*DW +: DW];
    assign b22 = op_b[IDX_22*DW +: DW];

    // Row/column streams skewed by one cycle; the last feed slot flushes zeros.
    always_comb begin
        a1 = '0;
        a2 = '0;
        b1 = '0;
        b2 = '0;
        if (feed_en) begin
            case (k)
                2'd0: begin
                    a1 = a11;
                    b1 = b11;
                end
                2'd1: begin
                    a1 = a12;
                    b1 = b21;
                    a2 = a21;
                    b2 = b12;
                end
                2'd2: begin
                    a2 = a22;
                    b2 = b22;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/systolic_ctrl_2by2.sv
// Sequencer for the 2x2 systolic array: accepts one operand pair, clears the
// PE accumulators, streams skewed operands, waits for the array to drain and
// captures C = A*B for the host.
// Build macro SYSA_PERF_CNT_EN adds a saturating 16-bit completed-op counter.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; operands latched on accept
// CLEAR | array accumulators held in reset for one cycle
// FEED  | k = 0..3 operand streaming
// DRAIN | DRAIN_CYC cycles for the last products to settle; capture
// DONE  | result valid, waiting for res_ready
module systolic_ctrl_2by2
    import sysa_pkg::*;
#(
    parameter int DW        = SYSA_DW,
    parameter int DRAIN_CYC = 1
) (
    input  logic               clk,
    input  logic               reset,
    systolic_ctrl_2by2_if.slave host,
    output logic               arr_reset,
    output logic [DW-1:0]      a1,
    output logic [DW-1:0]      a2,
    output logic [DW-1:0]      b1,
    output logic [DW-1:0]      b2,
    input  logic [DW-1:0]      c1,
    input  logic [DW-1:0]      c2,
    input  logic [DW-1:0]      c3,
    input  logic [DW-1:0]      c4
`ifdef SYSA_PERF_CNT_EN
    ,
    output logic [15:0]        op_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_CLEAR = CLEAR;
    localparam logic [2:0] S_FEED  = FEED;
    localparam logic [2:0] S_DRAIN = DRAIN;
    localparam logic [2:0] S_DONE  = DONE;

    localparam logic [1:0] K_LAST     = 2'(FEED_LEN - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

    logic [2:0]      state;
    logic [1:0]      k;
    logic [3:0]      drain_cnt;
    logic [4*DW-1:0] op_a;
    logic [4*DW-1:0] op_b;
    logic [4*DW-1:0] res_q;
    logic            feed_en;

    // Main sequencer: state, feed index, drain timer, operand and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            k         <= '0;
            drain_cnt <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.start) begin
                        op_a  <= host.mat_a;
                        op_b  <= host.mat_b;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    k     <= '0;
                    state <= S_FEED;
                end
                S_FEED: begin
                    if (k == K_LAST) begin
                        k         <= '0;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= S_DRAIN;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        res_q <= {c4, c3, c2, c1};
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (host.res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign feed_en        = (state == S_FEED);
    assign host.busy      = (state != S_IDLE);
    assign host.res_valid = (state == S_DONE);
    assign host.res       = res_q;

    // Array reset follows the block reset directly so an abort clears it at once.
    assign arr_reset = reset & (state != S_CLEAR);

    sysa_feed_mux_2by2 #(
        .DW(DW)
    ) u_feed_mux (
        .feed_en (feed_en),
        .k       (k),
        .op_a    (op_a),
        .op_b    (op_b),
        .a1      (a1),
        .a2      (a2),
        .b1      (b1),
        .b2      (b2)
    );

`ifdef SYSA_PERF_CNT_EN
    // Count completed result handshakes, sticking at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_cnt <= '0;
        end else if ((state == S_DONE) && host.res_ready && (op_cnt != 16'hFFFF)) begin
            op_cnt <= op_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl_2by2.sv
// Bench for systolic_ctrl_2by2 with a behavioural 2x2 PE array attached and a
// plain matrix-multiply reference for the expected results.
module tb_systolic_ctrl_2by2;
    import sysa_pkg::*;

    localparam int DW        = 8;
    localparam int DRAIN_CYC = 1;
    localparam int LAT       = 6 + DRAIN_CYC;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_ctrl_2by2_if #(.DW(DW)) host ();

    logic          arr_reset;
    logic [DW-1:0] a1, a2, b1, b2;
    logic [DW-1:0] c1, c2, c3, c4;
`ifdef SYSA_PERF_CNT_EN
    logic [15:0]   op_cnt;
`endif

    systolic_ctrl_2by2 #(
        .DW        (DW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (host),
        .arr_reset (arr_reset),
        .a1        (a1),
        .a2        (a2),
        .b1        (b1),
        .b2        (b2),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4)
`ifdef SYSA_PERF_CNT_EN
        ,
        .op_cnt    (op_cnt)
`endif
    );

    // Behavioural output-stationary 2x2 array: a flows right, b flows down.
    logic [DW-1:0] acc11, acc12, acc21, acc22;
    logic [DW-1:0] ap11, bp11, ap21, bp12;
    always @(posedge clk or negedge arr_reset) begin
        if (!arr_reset) begin
            acc11 <= '0; acc12 <= '0; acc21 <= '0; acc22 <= '0;
            ap11  <= '0; bp11  <= '0; ap21  <= '0; bp12  <= '0;
        end else begin
            acc11 <= acc11 + DW'(a1 * b1);
            acc12 <= acc12 + DW'(ap11 * b2);
            acc21 <= acc21 + DW'(a2 * bp11);
            acc22 <= acc22 + DW'(ap21 * bp12);
            ap11  <= a1;
            bp11  <= b1;
            ap21  <= a2;
            bp12  <= b2;
        end
    end
    assign c1 = acc11;
    assign c2 = acc12;
    assign c3 = acc21;
    assign c4 = acc22;

    int errors = 0;
    int checks = 0;

    // Reference C = A*B mod 2^DW, packed {c22,c21,c12,c11}.
    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        int x [4];
        int y [4];
        int c [4];
        for (int i = 0; i < 4; i++) begin
            x[i] = int'(a[i*8 +: 8]);
            y[i] = int'(b[i*8 +: 8]);
        end
        c[0] = (x[0] * y[0] + x[1] * y[2]) % 256;
        c[1] = (x[0] * y[1] + x[1] * y[3]) % 256;
        c[2] = (x[2] * y[0] + x[3] * y[2]) % 256;
        c[3] = (x[2] * y[1] + x[3] * y[3]) % 256;
        return {8'(c[3]), 8'(c[2]), 8'(c[1]), 8'(c[0])};
    endfunction

    // Pulse start for one accepting edge; returns at the following falling edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        host.mat_a = a;
        host.mat_b = b;
        host.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        host.start = 1'b0;
    endtask

    // Cycles from the accept edge until res_valid, plus arr_reset-low samples.
    task automatic wait_valid(output int lat, output int clr_lows);
        lat = 1;
        clr_lows = (arr_reset === 1'b0) ? 1 : 0;
        while (host.res_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (arr_reset === 1'b0) clr_lows++;
        end
    endtask

    task automatic finish_op();
        host.res_ready = 1'b1;
        @(negedge clk);
        host.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        host.start = 1'b0;
        host.mat_a = '0;
        host.mat_b = '0;
        host.res_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (host.busy !== 1'b0 || host.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b res_valid=%b expected 0 0", host.busy, host.res_valid);
        end
        checks++;
        if (host.res !== 32'h0 || {a1, a2, b1, b2} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: res=%h feeds=%h expected 0 0", host.res, {a1, a2, b1, b2});
        end
        checks++;
        if (arr_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_arr: arr_reset=%b expected 0", arr_reset);
        end
`ifdef SYSA_PERF_CNT_EN
        checks++;
        if (op_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_opcnt: op_cnt=%0d expected 0", op_cnt);
        end
`endif
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (arr_reset !== 1'b1 || host.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: arr_reset=%b busy=%b expected 1 0", arr_reset, host.busy);
        end
    endtask

    task automatic test_basic();
        int lat, cl;
        start_op(32'h04030201, 32'h08070605);
        wait_valid(lat, cl);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (host.res !== 32'h322B1613) begin
            errors++;
            $display("FAIL basic_res: got %h expected %h", host.res, 32'h322B1613);
        end
        finish_op();
        checks++;
        if (host.busy !== 1'b0 || host.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b res_valid=%b expected 0 0", host.busy, host.res_valid);
        end
    endtask

    task automatic test_wrap();
        int lat, cl;
        start_op(32'h10101010, 32'h10101010);
        wait_valid(lat, cl);
        checks++;
        if (host.res !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero: got %h expected %h", host.res, 32'h0);
        end
        finish_op();
        start_op(32'h01000001, 32'h04030201);
        wait_valid(lat, cl);
        checks++;
        if (host.res !== 32'h04030201) begin
            errors++;
            $display("FAIL wrap_identity: got %h expected %h", host.res, 32'h04030201);
        end
        finish_op();
    endtask

    task automatic test_random();
        int lat, cl;
        logic [31:0] a, b, exp;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            exp = matmul(a, b);
            start_op(a, b);
            wait_valid(lat, cl);
            checks++;
            if (lat != LAT || host.res !== exp) begin
                errors++;
                $display("FAIL random_%0d: res=%h lat=%0d expected res=%h lat=%0d", i, host.res, lat, exp, LAT);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat, cl;
        logic [31:0] a, b, exp;
        a = $urandom;
        b = $urandom;
        exp = matmul(a, b);
        start_op(a, b);
        wait_valid(lat, cl);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                host.start = 1'b1;
                host.mat_a = ~a;
            end else begin
                host.start = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (host.res_valid !== 1'b1 || host.res !== exp) begin
                errors++;
                $display("FAIL bp_hold_%0d: res_valid=%b res=%h expected 1 %h", i, host.res_valid, host.res, exp);
            end
        end
        host.start = 1'b0;
        finish_op();
        checks++;
        if (host.busy !== 1'b0 || host.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: busy=%b res_valid=%b expected 0 0", host.busy, host.res_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (host.busy !== 1'b0 || host.res !== exp) begin
            errors++;
            $display("FAIL bp_no_queue: busy=%b res=%h expected 0 %h", host.busy, host.res, exp);
        end
    endtask

    task automatic test_clear();
        int lat, cl;
        logic [31:0] a, b;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 32'h0A0B0C0D : 32'h01020304;
            b = (i == 0) ? 32'h11223344 : 32'h05060708;
            start_op(a, b);
            wait_valid(lat, cl);
            checks++;
            if (cl != 1) begin
                errors++;
                $display("FAIL clear_pulse_%0d: arr_reset low %0d cycles expected 1", i, cl);
            end
            checks++;
            if (host.res !== matmul(a, b)) begin
                errors++;
                $display("FAIL clear_res_%0d: got %h expected %h", i, host.res, matmul(a, b));
            end
            finish_op();
        end
    endtask

    task automatic test_reset_mid_feed();
        int lat, cl;
        logic [31:0] a, b;
        a = 32'h14131211;
        b = 32'h24232221;
        start_op(a, b);
        @(negedge clk);
        checks++;
        if ({a1, b1, a2, b2} !== {8'h11, 8'h21, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL feed_k0: got %h expected %h", {a1, b1, a2, b2}, {8'h11, 8'h21, 8'h00, 8'h00});
        end
        @(negedge clk);
        checks++;
        if ({a1, b1, a2, b2} !== {8'h12, 8'h23, 8'h13, 8'h22}) begin
            errors++;
            $display("FAIL feed_k1: got %h expected %h", {a1, b1, a2, b2}, {8'h12, 8'h23, 8'h13, 8'h22});
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (host.busy !== 1'b0 || host.res_valid !== 1'b0 || {a1, a2, b1, b2} !== 32'h0 || arr_reset !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b res_valid=%b feeds=%h arr_reset=%b expected 0 0 0 0",
                     host.busy, host.res_valid, {a1, a2, b1, b2}, arr_reset);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (host.res !== 32'h0 || host.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_cleared: res=%h busy=%b expected 0 0", host.res, host.busy);
        end
        a = $urandom;
        b = $urandom;
        start_op(a, b);
        wait_valid(lat, cl);
        checks++;
        if (lat != LAT || host.res !== matmul(a, b)) begin
            errors++;
            $display("FAIL abort_fresh: res=%h lat=%0d expected %h %0d", host.res, lat, matmul(a, b), LAT);
        end
        finish_op();
    endtask

`ifdef SYSA_PERF_CNT_EN
    task automatic test_perf_cnt();
        int lat, cl;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            start_op($urandom, $urandom);
            wait_valid(lat, cl);
            finish_op();
        end
        checks++;
        if (op_cnt !== 16'd3) begin
            errors++;
            $display("FAIL perf_count: got %0d expected 3", op_cnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (op_cnt !== 16'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d expected 0", op_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_backpressure();
        test_clear();
        test_reset_mid_feed();
`ifdef SYSA_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl_2by2.md
Name: systolic_ctrl_2by2

Overview:
- Sequencer for the 2x2 systolic array (`systolic_array_2by2`, four `pe_2by2` instances).
- Accepts one 2x2 operand pair A and B via a start handshake and clears the PE accumulators.
- Drives the skewed a1/a2/b1/b2 operand streams, waits for the array to drain, then captures c1..c4 as result C = A*B.
- Sits between the host/register interface and the array instance in the top level.

Parameters:
- DW, 8, element width of operands and results; must match the array datapath width.
- DRAIN_CYC, 1, idle cycles after the last feed cycle before capture; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- mat_a  in  4*DW  packed {a22,a21,a12,a11}; sampled on accept.
- mat_b  in  4*DW  packed {b22,b21,b12,b11}; sampled on accept.
- busy  out  1  high in every state except IDLE.
- arr_reset  out  1  active-low reset to the array; low while reset is low or state is CLEAR.
- a1,a2,b1,b2  out  DW each  operand streams to the array.
- c1,c2,c3,c4  in  DW each  accumulator outputs from the array.
- res  out  4*DW  packed {c4,c3,c2,c1}, captured.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (reset=0, asynchronous) puts the block in IDLE with all of the following cleared:
  - operand registers, res, feed counter = 0;
  - busy = 0, res_valid = 0;
  - a1/a2/b1/b2 = 0;
  - arr_reset = 0 while reset is low.
- State machine:
  - IDLE: if start=1, latch mat_a/mat_b and go to CLEAR.
  - CLEAR: one cycle with arr_reset=0 and feeds 0; then go to FEED with k=0.
  - FEED: 4 cycles, k = 0..3, then go to DRAIN.
  - DRAIN: DRAIN_CYC cycles with feeds 0. On the final DRAIN edge, capture res <= {c4,c3,c2,c1} and go to DONE.
  - DONE: res_valid=1. If res_ready=1, go to IDLE; res_valid falls on the next cycle.
- Feed schedule, decoded from registered state and k (no combinational path from inputs); any value not listed is 0:
  - a1: k0 = a11, k1 = a12.
  - b1: k0 = b11, k1 = b21.
  - a2: k1 = a21, k2 = a22.
  - b2: k1 = b12, k2 = b22.
  - k3 drives all feeds to 0.
- Latency: start accepted at cycle T gives res_valid=1 from cycle T+6+DRAIN_CYC (T+7 at default).
- start outside IDLE is ignored, including in DONE; no queuing.
- res holds its value until the next capture. res_valid stays high until the res_ready handshake completes.
- Arithmetic is performed entirely in the array (mod 2^DW). The controller does no arithmetic on data.
- reset low mid-operation aborts immediately: state returns to IDLE, any partial result is discarded, and arr_reset is asserted.

Optional Feature:
- Macro: SYSA_PERF_CNT_EN.
- Defined: adds output port op_cnt (16 bits).
  - Increments on each res_valid & res_ready handshake.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: no op_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package sysa_pkg:
  - state enum {IDLE, CLEAR, FEED, DRAIN, DONE};
  - DW default constant;
  - element index constants for the packed matrix layout;
  - FEED_LEN = 4.
- One sub-module: sysa_feed_mux_2by2. Combinational; maps (state==FEED, k, latched A/B) to a1/a2/b1/b2.

Test Plan:
- Basic multiply: A=[[1,2],[3,4]] (mat_a={4,3,2,1}), B=[[5,6],[7,8]] (mat_b={8,7,6,5}), start, res_ready=1 → res={50,43,22,19}; res_valid first high at start cycle+7.
- Wrap-around: all A and B elements = 16 → res = 0. With A = identity and B={4,3,2,1} → res = B.
- Back-pressure and ignored start:
  - hold res_ready=0 for 10 cycles; pulse start during DONE;
  - expect res_valid and res stable and the start ignored;
  - then res_ready=1 → IDLE and busy=0 next cycle.
- Accumulator clear: run two consecutive operations with different operands → second res reflects only the second operand pair. Check arr_reset is low for exactly one cycle per operation.
- Reset mid-FEED: drive reset=0 at k=1 → busy, res_valid, and feeds go to 0 asynchronously. After release, a fresh op gives the correct result.
- SYSA_PERF_CNT_EN defined: three completed handshakes → op_cnt=3; reset → op_cnt=0.
